// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline-stage register with an optional skid entry.
// Other features: synchronous flush with optional payload zeroing, and
// saturating stall/bubble performance counters.
//
// Ports:
//   clk_i, rst_i      clock; asynchronous active-high reset
//   flush_i           synchronous kill of all held entries
//   cnt_clr_i         synchronous clear of both counters
//   up_valid_i/up_ready_o/up_data_i   upstream handshake and payload
//   dn_valid_o/dn_ready_i/dn_data_o   downstream handshake and payload
//   occupancy_o       held entries (0, 1 or 2)
//   stall_cnt_o       cycles with dn_valid_o=1 and dn_ready_i=0
//   bubble_cnt_o      cycles with dn_valid_o=0
module pipe_stage_elastic #(
    parameter int unsigned DATA_W        = 256,
    parameter bit          SKID_EN       = 1'b1,
    parameter bit          CLEAR_ON_KILL = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [DATA_W-1:0]   main_q;
    logic [DATA_W-1:0]   main_d;
    logic [DATA_W-1:0]   skid_q;
    logic [DATA_W-1:0]   skid_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    bubble_cnt_q;
    logic                up_xfer;
    logic                dn_xfer;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next payload values
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Flush overrides everything, including a beat accepted this cycle
            state_d = ST_EMPTY;
            if (CLEAR_ON_KILL) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        main_d  = up_data_i;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (up_xfer && dn_xfer) begin
                        main_d = up_data_i;
                    end else if (up_xfer && SKID_EN) begin
                        skid_d  = up_data_i;
                        state_d = ST_SKID;
                    end else if (dn_xfer) begin
                        state_d = ST_EMPTY;
                        if (CLEAR_ON_KILL) begin
                            main_d = '0;
                        end
                    end
                end
                ST_SKID: begin
                    // Skid beat always follows the main beat
                    if (dn_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                        if (CLEAR_ON_KILL) begin
                            skid_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Outputs decoded from state; ready is combinational only without skid
    always_comb begin
        dn_valid_o  = (state_q != ST_EMPTY);
        occupancy_o = 2'd0;
        case (state_q)
            ST_FULL: occupancy_o = 2'd1;
            ST_SKID: occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
        if (SKID_EN) begin
            up_ready_o = (state_q != ST_SKID);
        end else begin
            up_ready_o = (state_q == ST_EMPTY) || dn_ready_i;
        end
    end

    assign up_xfer   = up_valid_i & up_ready_o;
    assign dn_xfer   = dn_valid_o & dn_ready_i;
    assign dn_data_o = main_q;

    // Payload registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (dn_valid_o && !dn_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!dn_valid_o && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic. Three instances share one stimulus:
//   0: skid entry, 16-bit counters
//   1: single entry (combinational ready), 16-bit counters
//   2: skid entry, 4-bit counters (saturation)
// Each instance is tracked by a small FIFO model of held beats.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 16;
    localparam int unsigned NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          cnt_clr;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          dn_ready;

    logic          up_ready [NI];
    logic          dn_valid [NI];
    logic [DW-1:0] dn_data  [NI];
    logic [1:0]    occ      [NI];
    logic [15:0]   stall    [NI];
    logic [15:0]   bubble   [NI];
    logic [3:0]    stall_s;
    logic [3:0]    bubble_s;

    assign stall[2]  = 16'(stall_s);
    assign bubble[2] = 16'(bubble_s);

    int total = 0;
    int bad   = 0;

    // Model: held beats per instance, oldest first
    logic [DW-1:0] mdat [NI][2];
    int            mn   [NI];
    int            mst  [NI];
    int            mbu  [NI];
    int            cap  [NI] = '{2, 1, 2};
    int            cmax [NI] = '{65535, 65535, 15};

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .SKID_EN(1'b1), .CLEAR_ON_KILL(1'b1), .CNT_W(16)) u_skid (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .cnt_clr_i(cnt_clr),
        .up_valid_i(up_valid), .up_ready_o(up_ready[0]), .up_data_i(up_data),
        .dn_valid_o(dn_valid[0]), .dn_ready_i(dn_ready), .dn_data_o(dn_data[0]),
        .occupancy_o(occ[0]), .stall_cnt_o(stall[0]), .bubble_cnt_o(bubble[0])
    );

    pipe_stage_elastic #(.DATA_W(DW), .SKID_EN(1'b0), .CLEAR_ON_KILL(1'b1), .CNT_W(16)) u_pass (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .cnt_clr_i(cnt_clr),
        .up_valid_i(up_valid), .up_ready_o(up_ready[1]), .up_data_i(up_data),
        .dn_valid_o(dn_valid[1]), .dn_ready_i(dn_ready), .dn_data_o(dn_data[1]),
        .occupancy_o(occ[1]), .stall_cnt_o(stall[1]), .bubble_cnt_o(bubble[1])
    );

    pipe_stage_elastic #(.DATA_W(DW), .SKID_EN(1'b1), .CLEAR_ON_KILL(1'b1), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .cnt_clr_i(cnt_clr),
        .up_valid_i(up_valid), .up_ready_o(up_ready[2]), .up_data_i(up_data),
        .dn_valid_o(dn_valid[2]), .dn_ready_i(dn_ready), .dn_data_o(dn_data[2]),
        .occupancy_o(occ[2]), .stall_cnt_o(stall_s), .bubble_cnt_o(bubble_s)
    );

    function automatic bit model_ready(int i);
        if (cap[i] == 2) return mn[i] < 2;
        return (mn[i] == 0) || dn_ready;
    endfunction

    function automatic logic [DW-1:0] model_data(int i);
        return (mn[i] > 0) ? mdat[i][0] : '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mn[i]  = 0;
            mst[i] = 0;
            mbu[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit up;
            bit dn;
            up = up_valid && model_ready(i);
            dn = (mn[i] > 0) && dn_ready;
            if (cnt_clr) begin
                mst[i] = 0;
                mbu[i] = 0;
            end else begin
                if (mn[i] > 0 && !dn_ready && mst[i] < cmax[i]) mst[i]++;
                if (mn[i] == 0 && mbu[i] < cmax[i]) mbu[i]++;
            end
            if (flush) begin
                mn[i] = 0;
            end else begin
                if (dn) begin
                    mdat[i][0] = mdat[i][1];
                    mn[i]--;
                end
                if (up) begin
                    mdat[i][mn[i]] = up_data;
                    mn[i]++;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        up_valid = 1'b0;
        up_data  = '0;
        dn_ready = 1'b0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (dn_valid[i] !== 1'b0 || dn_data[i] !== '0 || occ[i] !== 2'd0) begin
                bad++;
                $display("FAIL reset_out[%0d] got v=%0b d=%0h occ=%0d exp v=0 d=0 occ=0",
                         i, dn_valid[i], dn_data[i], occ[i]);
            end
            total++;
            if (up_ready[i] !== 1'b1 || stall[i] !== 16'd0 || bubble[i] !== 16'd0) begin
                bad++;
                $display("FAIL reset_rdy_cnt[%0d] got rdy=%0b st=%0d bu=%0d exp rdy=1 st=0 bu=0",
                         i, up_ready[i], stall[i], bubble[i]);
            end
        end
    endtask

    task automatic test_first_beat();
        up_valid = 1'b1;
        up_data  = 16'h00A5;
        dn_ready = 1'b1;
        tick();
        up_valid = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (dn_valid[i] !== 1'b1 || dn_data[i] !== 16'h00A5) begin
                bad++;
                $display("FAIL first_beat[%0d] got v=%0b d=%0h exp v=1 d=a5", i, dn_valid[i], dn_data[i]);
            end
            total++;
            if (bubble[i] !== 16'd1) begin
                bad++;
                $display("FAIL first_bubble[%0d] got %0d exp 1", i, bubble[i]);
            end
        end
        tick();
    endtask

    task automatic test_skid_fill();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = 16'h0001;
        tick();
        up_data  = 16'h0002;
        tick();
        up_valid = 1'b0;
        #1;
        total++;
        if (up_ready[0] !== 1'b0 || occ[0] !== 2'd2) begin
            bad++;
            $display("FAIL skid_full got rdy=%0b occ=%0d exp rdy=0 occ=2", up_ready[0], occ[0]);
        end
        repeat (3) tick();
        dn_ready = 1'b1;
        #1;
        total++;
        if (dn_valid[0] !== 1'b1 || dn_data[0] !== 16'h0001) begin
            bad++;
            $display("FAIL skid_out1 got v=%0b d=%0h exp v=1 d=1", dn_valid[0], dn_data[0]);
        end
        tick();
        total++;
        if (dn_valid[0] !== 1'b1 || dn_data[0] !== 16'h0002) begin
            bad++;
            $display("FAIL skid_out2 got v=%0b d=%0h exp v=1 d=2", dn_valid[0], dn_data[0]);
        end
        tick();
        total++;
        if (dn_valid[0] !== 1'b0 || stall[0] !== 16'd4 || stall[2] !== 16'd4) begin
            bad++;
            $display("FAIL skid_stall got v=%0b st0=%0d st2=%0d exp v=0 st=4",
                     dn_valid[0], stall[0], stall[2]);
        end
    endtask

    task automatic test_flush();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = 16'h0033;
        tick();
        up_data  = 16'h0044;
        tick();
        // Beat offered during flush must be discarded
        up_data  = 16'h0055;
        flush    = 1'b1;
        #1;
        total++;
        if (occ[0] !== 2'd2 || up_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL pre_flush got occ0=%0d rdy1=%0b exp occ0=2 rdy1=0", occ[0], up_ready[1]);
        end
        tick();
        flush    = 1'b0;
        up_valid = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (dn_valid[i] !== 1'b0 || dn_data[i] !== '0 || occ[i] !== 2'd0 || up_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL flush[%0d] got v=%0b d=%0h occ=%0d rdy=%0b exp v=0 d=0 occ=0 rdy=1",
                         i, dn_valid[i], dn_data[i], occ[i], up_ready[i]);
            end
            total++;
            if (stall[i] !== 16'(mst[i]) || bubble[i] !== 16'(mbu[i])) begin
                bad++;
                $display("FAIL flush_cnt[%0d] got st=%0d bu=%0d exp st=%0d bu=%0d",
                         i, stall[i], bubble[i], mst[i], mbu[i]);
            end
        end
    endtask

    task automatic test_passthrough();
        bit            pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [DW-1:0] rcv [4];
        int            nr  = 0;
        int            idx = 0;
        bit            exp_rdy;
        for (int c = 0; c < 8; c++) begin
            up_valid = (idx < 3);
            up_data  = DW'(16'h0010 + idx);
            dn_ready = pat[c];
            #1;
            exp_rdy = (mn[1] == 0) ? 1'b1 : pat[c];
            total++;
            if (up_ready[1] !== exp_rdy) begin
                bad++;
                $display("FAIL pass_ready cyc=%0d got %0b exp %0b", c, up_ready[1], exp_rdy);
            end
            if (dn_valid[1] && dn_ready) begin
                if (nr < 4) rcv[nr] = dn_data[1];
                nr++;
            end
            if (up_valid && up_ready[1]) idx++;
            tick();
        end
        up_valid = 1'b0;
        total++;
        if (nr !== 3 || idx !== 3) begin
            bad++;
            $display("FAIL pass_count got recv=%0d sent=%0d exp 3", nr, idx);
        end
        for (int k = 0; k < 3 && k < nr; k++) begin
            total++;
            if (rcv[k] !== DW'(16'h0010 + k)) begin
                bad++;
                $display("FAIL pass_order[%0d] got %0h exp %0h", k, rcv[k], 16'h0010 + k);
            end
        end
    endtask

    task automatic test_saturate();
        dn_ready = 1'b1;
        repeat (2) tick();
        dn_ready = 1'b0;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        up_valid = 1'b1;
        up_data  = 16'h0077;
        tick();
        up_valid = 1'b0;
        repeat (20) tick();
        #1;
        total++;
        if (stall[2] !== 16'h000F) begin
            bad++;
            $display("FAIL sat_stall got %0h exp f", stall[2]);
        end
        total++;
        if (stall[0] !== 16'd20) begin
            bad++;
            $display("FAIL wide_stall got %0d exp 20", stall[0]);
        end
        // Clear wins over a pending increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        total++;
        if (stall[2] !== 16'd0 || bubble[2] !== 16'd0) begin
            bad++;
            $display("FAIL sat_clear got st=%0d bu=%0d exp 0 0", stall[2], bubble[2]);
        end
        dn_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = 16'h005A;
        tick();
        up_valid = 1'b0;
        #1;
        total++;
        if (dn_valid[0] !== 1'b1 || occ[0] !== 2'd1) begin
            bad++;
            $display("FAIL arst_pre got v=%0b occ=%0d exp v=1 occ=1", dn_valid[0], occ[0]);
        end
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (dn_valid[i] !== 1'b0 || occ[i] !== 2'd0 || dn_data[i] !== '0 || up_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL arst[%0d] got v=%0b occ=%0d d=%0h rdy=%0b exp v=0 occ=0 d=0 rdy=1",
                         i, dn_valid[i], occ[i], dn_data[i], up_ready[i]);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            up_valid = ($urandom_range(0, 3) != 0);
            up_data  = DW'($urandom);
            dn_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            cnt_clr  = ($urandom_range(0, 31) == 0);
            #1;
            for (int i = 0; i < NI; i++) begin
                total++;
                if (dn_valid[i] !== (mn[i] > 0) || dn_data[i] !== model_data(i) || occ[i] !== 2'(mn[i])) begin
                    bad++;
                    $display("FAIL rnd_out[%0d] cyc=%0d got v=%0b d=%0h occ=%0d exp v=%0b d=%0h occ=%0d",
                             i, c, dn_valid[i], dn_data[i], occ[i], mn[i] > 0, model_data(i), mn[i]);
                end
                total++;
                if (up_ready[i] !== model_ready(i)) begin
                    bad++;
                    $display("FAIL rnd_ready[%0d] cyc=%0d got %0b exp %0b", i, c, up_ready[i], model_ready(i));
                end
                total++;
                if (stall[i] !== 16'(mst[i]) || bubble[i] !== 16'(mbu[i])) begin
                    bad++;
                    $display("FAIL rnd_cnt[%0d] cyc=%0d got st=%0d bu=%0d exp st=%0d bu=%0d",
                             i, c, stall[i], bubble[i], mst[i], mbu[i]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_skid_fill();
        test_flush();
        test_passthrough();
        test_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline-stage register that generalises the fixed ID/EX-style boundary registers into one reusable block for any stage boundary in the core. It carries an opaque payload bus between two stages using a valid/ready handshake. It optionally adds a skid entry that registers the upstream ready path. It supports synchronous flush with optional payload zeroing, and maintains saturating stall and bubble counters for performance analysis.

## Interface
- DATA_W, 256: payload width in bits, at least 1.
- SKID_EN, 1: 1 adds a second (skid) entry and makes up_ready_o a registered signal; 0 gives a single entry with combinational ready pass-through.
- CLEAR_ON_KILL, 1: 1 zeroes payload registers on reset, flush and whenever an entry empties; 0 zeroes them on reset only.
- CNT_W, 16: width of each performance counter.
- clk_i  in  1  clock; all state is rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous kill of all held entries.
- cnt_clr_i  in  1  synchronous clear of both counters.
- up_valid_i  in  1  upstream beat valid.
- up_ready_o  out  1  stage can accept a beat.
- up_data_i  in  DATA_W  upstream payload.
- dn_valid_o  out  1  downstream beat valid.
- dn_ready_i  in  1  downstream accepts.
- dn_data_o  out  DATA_W  downstream payload, driven by the main register.
- occupancy_o  out  2  number of held entries: 0, 1 or 2.
- stall_cnt_o  out  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0.
- bubble_cnt_o  out  CNT_W  cycles with dn_valid_o=0.

## Operation
- Handshake terms:
  - An up transfer happens when up_valid_i & up_ready_o.
  - A dn transfer happens when dn_valid_o & dn_ready_i.
  - While dn_valid_o=1 and dn_ready_i=0, dn_data_o and dn_valid_o hold stable.
- States:
  - EMPTY: no entry held.
  - FULL: main entry held.
  - SKID: main and skid entries held; reachable only when SKID_EN=1.
- dn_valid_o equals the main entry's valid bit.
- up_ready_o:
  - SKID_EN=1: up_ready_o = not SKID.
  - SKID_EN=0: up_ready_o = not dn_valid_o, or dn_ready_i.
- EMPTY transitions:
  - up transfer: main <= up_data_i, go to FULL.
- FULL transitions:
  - up and dn transfer together: main <= up_data_i, stay in FULL.
  - up transfer only (SKID_EN=1): skid <= up_data_i, go to SKID.
  - dn transfer only: go to EMPTY; main zeroed if CLEAR_ON_KILL=1.
  - otherwise: hold.
- SKID transitions:
  - dn transfer: main <= skid, go to FULL; skid zeroed if CLEAR_ON_KILL=1.
  - otherwise: hold; no up transfer is possible.
- Flush:
  - flush_i=1 takes priority over every transition; next state is EMPTY.
  - All valid bits clear; payloads zeroed if CLEAR_ON_KILL=1.
  - A beat accepted in the flush cycle is discarded.
  - up_ready_o is not gated by flush_i.
- Counters:
  - Each counter increments by 1 on its condition and saturates at all-ones.
  - cnt_clr_i=1 loads 0 in that cycle; the clear wins over an increment.
  - flush_i does not affect counters.
  - Counters sample conditions in the flush cycle normally.
- occupancy_o: EMPTY=0, FULL=1, SKID=2.

## Timing
- Reset state (asynchronous, immediate):
  - State is EMPTY.
  - dn_valid_o=0, dn_data_o=0, occupancy_o=0, both counters 0.
  - up_ready_o=1; with SKID_EN=0 this holds because dn_valid_o=0.
- Reset asserted mid-operation drops all held beats without completing any handshake.
- Latency: a beat accepted at edge N is visible on dn_valid_o/dn_data_o after edge N, i.e. in cycle N+1.
- Throughput is 1 beat per cycle when dn_ready_i is held at 1, in both SKID_EN modes.
- Ready path:
  - SKID_EN=1: up_ready_o depends only on registered state, with no combinational path from dn_ready_i.
  - SKID_EN=0: up_ready_o has a combinational path from dn_ready_i.
- Ordering: beats leave in arrival order; the skid beat always follows the main beat.
- No beat is duplicated or dropped except by flush or reset.
- Simultaneous flush_i and cnt_clr_i: both take effect.

## Test plan
- Reset, then up_valid_i=1 with data 0xA5 for one cycle and dn_ready_i=1 -> dn_valid_o=1 with 0xA5 in the next cycle; bubble_cnt_o=1 after that first cycle.
- SKID_EN=1, dn_ready_i=0, send beats 0x1, 0x2:
  - up_ready_o drops to 0 after the second beat and occupancy_o=2.
  - Raise dn_ready_i -> 0x1 then 0x2 on consecutive cycles.
  - stall_cnt_o equals the cycles held.
- Flush in SKID state with CLEAR_ON_KILL=1 -> next cycle dn_valid_o=0, dn_data_o=0, occupancy_o=0, up_ready_o=1; counters unchanged.
- SKID_EN=0, continuous up_valid_i with dn_ready_i toggling 1,0,1 -> up_ready_o follows dn_ready_i whenever FULL; no beat lost, and the sequence 0x10,0x11,0x12 arrives in order.
- CNT_W=4, dn_ready_i=0 with one held beat for 20 cycles -> stall_cnt_o saturates at 0xF; cnt_clr_i pulse -> 0.
- Async rst_i pulse between clock edges while FULL -> dn_valid_o and occupancy_o drop to 0 immediately, before the next edge.
